// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : present_pkg
//  Description : Shared PRESENT-80 definitions. Holds the key, round-key and
//                round-counter widths, the key-generator state encoding and
//                the 4-bit PRESENT S-box used by both the key schedule and
//                the round datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package present_pkg;

    localparam int KEY_W = 80;
    localparam int RK_W  = 64;
    localparam int CNT_W = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // S-box packed as 16 nibbles; nibble n holds S[n].
    // S = C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX_TABLE[{n, 2'b00} +: 4];
    endfunction

endpackage : present_pkg
`default_nettype wire

// File: rtl/key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : key_schedule
//  Description : One combinational PRESENT-80 key-register update step:
//                rotate left by 61, S-box on the top nibble, XOR the 5-bit
//                round counter into bits 19..15.
//  Ports       : x  in  80  current key register
//                i  in  5   round counter (1..31)
//                r  out 80  updated key register
//  Revision    : 1.0 - initial release
// ============================================================================
module key_schedule
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] x,
    input  logic [4:0]       i,
    output logic [KEY_W-1:0] r
);

    logic [KEY_W-1:0] w_rot;

    // Rotating left by 61 equals rotating right by 19.
    assign w_rot = {x[18:0], x[79:19]};

    assign r = {sbox(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ i, w_rot[14:0]};

endmodule : key_schedule
`default_nettype wire

// File: rtl/present_key_gen.sv
`default_nettype none
// ============================================================================
//  Module      : present_key_gen
//  Description : Sequential PRESENT-80 round-key generator. Loads one 80-bit
//                user key and streams round keys K1..K(ROUNDS+1) over a
//                valid/ready interface, one key per cycle without stalls.
//                Optional feature macro: KEY_CACHE_EN (keeps a copy of the
//                last loaded key so 'replay' can restart the sequence).
//  Ports       : clk, rst_n (async, active low)
//                key[79:0], key_valid, key_ready   - key load handshake
//                flush                             - synchronous abort to IDLE
//                rk[63:0], rk_round[5:0], rk_last,
//                rk_valid, rk_ready                - round-key stream
//                replay                            - restart from cached key
//  Revision    : 1.0 - initial release
// ============================================================================
module present_key_gen
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              flush,
    output logic [RK_W-1:0]   rk,
    output logic [CNT_W-1:0]  rk_round,
    output logic              rk_last,
    output logic              rk_valid,
    input  logic              rk_ready,
    input  logic              replay
);

    localparam logic [CNT_W-1:0] c_last_round = CNT_W'(ROUNDS + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [KEY_W-1:0]  r_kreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [KEY_W-1:0]  w_kreg_step;
    logic [KEY_W-1:0]  w_start_key;
    logic              w_load;
    logic              w_replay;
    logic              w_start;
    logic              w_accept;
    logic              w_last;

    // ------------------------------------------------------------------
    // Handshake qualification. flush overrides every handshake; replay
    // overrides a coincident key offer.
    // ------------------------------------------------------------------
    assign w_last   = (r_cnt == c_last_round);
    assign w_accept = (r_state == RUN) && rk_ready && !flush;

`ifdef KEY_CACHE_EN
    logic [KEY_W-1:0] r_kcache;

    assign w_replay    = (r_state == IDLE) && replay && !flush;
    assign w_start_key = w_replay ? r_kcache : key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kcache <= '0;
        end else if (w_load) begin
            r_kcache <= key;
        end
    end
`else
    logic w_unused_replay;

    assign w_unused_replay = replay;
    assign w_replay        = 1'b0;
    assign w_start_key     = key;
`endif

    assign w_load  = (r_state == IDLE) && key_valid && !flush && !w_replay;
    assign w_start = w_load || w_replay;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_start)            w_next_state = RUN;
                RUN:  if (w_accept && w_last) w_next_state = IDLE;
                default:                      w_next_state = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key register and round counter. The step is only taken when a
    // non-final key is accepted, so the counter stops at ROUNDS+1.
    // ------------------------------------------------------------------
    key_schedule u_key_schedule (
        .x (r_kreg),
        .i (r_cnt[4:0]),
        .r (w_kreg_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kreg <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_cnt  <= '0;
        end else if (w_start) begin
            r_kreg <= w_start_key;
            r_cnt  <= CNT_W'(1);
        end else if (w_accept && !w_last) begin
            r_kreg <= w_kreg_step;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only, so rk_ready never reaches rk.
    // ------------------------------------------------------------------
    assign key_ready = (r_state == IDLE);
    assign rk_valid  = (r_state == RUN);
    assign rk        = r_kreg[KEY_W-1:KEY_W-RK_W];
    assign rk_round  = (r_state == RUN) ? r_cnt : '0;
    assign rk_last   = (r_state == RUN) && w_last;

endmodule : present_key_gen
`default_nettype wire

// File: tb/tb_present_key_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_key_gen
//  Description : Scoreboard bench for present_key_gen. Stimulus pushes the
//                expected round-key stream (from a behavioural PRESENT-80 key
//                schedule) into a queue; a monitor pops and compares on each
//                accepted round key and checks stability while stalled.
//                Honours KEY_CACHE_EN for the replay scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_present_key_gen;

    localparam int R  = 31;
    localparam int NK = R + 1;

    typedef struct {
        logic [63:0] rk;
        logic [5:0]  rnd;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [79:0] key = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        flush = 1'b0;
    logic [63:0] rk;
    logic [5:0]  rk_round;
    logic        rk_last;
    logic        rk_valid;
    logic        rk_ready = 1'b0;
    logic        replay = 1'b0;

    exp_t        q[$];
    logic [63:0] cap [1:NK];
    int          checks = 0;
    int          failures = 0;

    present_key_gen #(.ROUNDS(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .flush     (flush),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .replay    (replay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Behavioural reference: the PRESENT-80 key register update expressed
    // directly as rotate / S-box lookup / counter XOR on a plain variable.
    task automatic push_keys(input logic [79:0] k_in);
        logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        logic [79:0] k;
        logic [4:0]  rc;
        exp_t        e;
        k = k_in;
        for (int r = 1; r <= NK; r++) begin
            e.rk   = k[79:16];
            e.rnd  = 6'(r);
            e.last = (r == NK);
            q.push_back(e);
            rc = 5'(r);
            k = {k[18:0], k[79:19]};
            k[79:76] = sb[k[79:76]];
            k[19:15] = k[19:15] ^ rc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [79:0] k);
        key       = k;
        key_valid = 1'b1;
        chk("key_ready_before_load", 80'(key_ready), 80'd1);
        push_keys(k);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(q.size() == 0 && key_ready) && n < 600) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 80'(n < 600), 80'd1);
    endtask

    // ------------------------------------------------------------------
    // Monitor: inputs change just after the rising edge, so at the falling
    // edge they are exactly what the next rising edge will see.
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t        e;
        logic        stall_prev;
        logic        expect_idle;
        logic [63:0] prev_rk;
        logic [5:0]  prev_round;
        stall_prev  = 1'b0;
        expect_idle = 1'b0;
        prev_rk     = '0;
        prev_round  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev  = 1'b0;
                expect_idle = 1'b0;
            end else begin
                if (expect_idle) begin
                    chk("key_ready_after_last", 80'(key_ready), 80'd1);
                    chk("rk_valid_after_last", 80'(rk_valid), 80'd0);
                    expect_idle = 1'b0;
                end
                if (stall_prev) begin
                    chk("stall_rk_stable", 80'(rk), 80'(prev_rk));
                    chk("stall_round_stable", 80'(rk_round), 80'(prev_round));
                end
                if (rk_valid && rk_ready && !flush) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rk_round", 80'(rk_round), 80'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rk", 80'(rk), 80'(e.rk));
                        chk("rk_round", 80'(rk_round), 80'(e.rnd));
                        chk("rk_last", 80'(rk_last), 80'(e.last));
                        if (rk_round >= 6'd1 && rk_round <= 6'(NK)) cap[rk_round] = rk;
                        if (e.last) expect_idle = 1'b1;
                    end
                end
                stall_prev = rk_valid && !rk_ready && !flush;
                prev_rk    = rk;
                prev_round = rk_round;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int          n;
        logic [79:0] key_a;
        logic [79:0] key_b;

        // Reset values
        #3;
        chk("reset_key_ready", 80'(key_ready), 80'd1);
        chk("reset_rk_valid", 80'(rk_valid), 80'd0);
        chk("reset_rk", 80'(rk), 80'd0);
        chk("reset_rk_round", 80'(rk_round), 80'd0);
        chk("reset_rk_last", 80'(rk_last), 80'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. all-zero key, no backpressure
        rk_ready = 1'b1;
        load(80'h0);
        drain("zero_key");
        chk("zero_K1", 80'(cap[1]), 80'h0);
        chk("zero_K2", 80'(cap[2]), 80'(64'hc000000000000000));
        chk("zero_K32", 80'(cap[NK]), 80'(64'h6dab31744f41d700));

        // 2. published key; key offers during RUN must be ignored
        load(80'h8BA27A0EB8783AC96D59);
        key       = {$urandom, $urandom, 16'(($urandom))};
        key_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        key_valid = 1'b0;
        drain("vector_key");
        chk("vector_K1", 80'(cap[1]), 80'(64'h8BA27A0EB8783AC9));

        // 3. random key with 50% backpressure
        rk_ready = 1'b0;
        load({$urandom, $urandom, 16'(($urandom))});
        n = 0;
        while (!(q.size() == 0 && key_ready) && n < 600) begin
            rk_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("backpressure_timeout", 80'(n < 600), 80'd1);
        rk_ready = 1'b1;

        // 4. flush coincident with the accept of round 10
        load({$urandom, $urandom, 16'(($urandom))});
        n = 0;
        while (!(rk_valid && rk_round == 6'd10) && n < 100) begin
            tick();
            n++;
        end
        chk("flush_reach_round10", 80'(n < 100), 80'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rk_valid", 80'(rk_valid), 80'd0);
        chk("flush_key_ready", 80'(key_ready), 80'd1);
        chk("flush_rk_round", 80'(rk_round), 80'd0);
        chk("flush_remaining", 80'(q.size()), 80'(NK - 9));
        q.delete();
        load({$urandom, $urandom, 16'(($urandom))});
        drain("after_flush");

        // 5. asynchronous reset between clock edges while stalled in RUN
        rk_ready = 1'b0;
        load({$urandom, $urandom, 16'(($urandom))});
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rk_valid", 80'(rk_valid), 80'd0);
        chk("async_rst_key_ready", 80'(key_ready), 80'd1);
        chk("async_rst_rk", 80'(rk), 80'd0);
        chk("async_rst_rk_round", 80'(rk_round), 80'd0);
        chk("async_rst_rk_last", 80'(rk_last), 80'd0);
        q.delete();
        tick();
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        tick();

        // 6. replay versus a coincident key offer
        key_a = {$urandom, $urandom, 16'(($urandom))};
        key_b = ~key_a;
        load(key_a);
        drain("replay_first");
        key       = key_b;
        key_valid = 1'b1;
        replay    = 1'b1;
`ifdef KEY_CACHE_EN
        push_keys(key_a);
`else
        push_keys(key_b);
`endif
        tick();
        key_valid = 1'b0;
        replay    = 1'b0;
        drain("replay_second");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_present_key_gen
`default_nettype wire
